hazard_scheduler: RTL and testbench
===================================

// Module: hazard_scheduler
// PURPOSE
//  Pipeline hazard controller for the 5-stage ARM core.
//  - Keeps its own shadow of in-flight instructions (E, M, W) fed from decode-stage fields.
//  - Drives fetch/decode stall, the D and E flushes, and the E-stage operand forwarding selects.
//  - Sequences PC-write (rd=r15) waits.
//  - Counts stall cycles for performance reporting.
// PARAMETERS
//  CNT_W   16  width of the saturating stall counter
//  PC_REG  15  register index treated as the PC (never forwarded, triggers PC-write wait)
// PORTS
//  clk          in   1      core clock, all state on rising edge
//  reset        in   1      asynchronous, active-low reset
//  ValidD       in   1      decode stage holds a real instruction
//  RA1D         in   4      decode read address 1 (post RegSrc mux)
//  RA2D         in   4      decode read address 2 (post RegSrc mux)
//  WA3D         in   4      decode destination register
//  RegWriteD    in   1      decode instruction writes the register file
//  MemToRegD    in   1      decode instruction is a load
//  BranchTakenE in   1      execute-stage branch resolved taken (cond passed)
//  StallF       out  1      hold PC register
//  StallD       out  1      hold fetch/decode pipe register
//  FlushD       out  1      bubble into fetch/decode pipe register
//  FlushE       out  1      bubble into decode/execute pipe register
//  ForwardAE    out  2      SrcA select: 00 RD1E, 01 ResultW, 10 ALUResultM
//  ForwardBE    out  2      SrcB select, same encoding
//  StallCount   out  CNT_W  saturating count of cycles with StallD=1
// BEHAVIOUR
//  Reset (reset=0, async):
//   - All shadow valids clear; FSM goes to IDLE; StallCount=0.
//   - Every output is 0 while reset is low.
//  Shadow pipeline:
//   - Stages E, M and W each hold {v, wa, rw, m2r}; stage E additionally holds {ra1, ra2}.
//   - Every cycle: W<=M and M<=E.
//   - E <= bubble (v=0) if FlushE=1; otherwise E <= D fields with v=ValidD.
//  Load-use:
//   - LU = ValidD & E.v & E.rw & E.m2r & (E.wa==RA1D | E.wa==RA2D).
//   - LU=1 -> StallF=1, StallD=1, FlushE=1 (one bubble per dependent load).
//  Branch:
//   - BranchTakenE=1 -> FlushD=1, FlushE=1, StallF=0, StallD=0.
//   - Branch overrides LU in the same cycle.
//  Forwarding (combinational from shadow state), evaluated for X in {ra1, ra2}:
//   - 10 if M.v & M.rw & M.wa==E.X & E.X!=PC_REG
//   - else 01 if the same condition holds for W
//   - else 00
//   - M has priority over W.
//  FSM {IDLE, PCWAIT}:
//   - IDLE->PCWAIT when ValidD & RegWriteD & WA3D==PC_REG & !StallD & !BranchTakenE.
//   - PCWAIT: StallF=1, FlushD=1 (Moore); StallD=0.
//   - PCWAIT->IDLE on the cycle W.v & W.rw & W.wa==PC_REG; outputs drop the following cycle.
//   - BranchTakenE in PCWAIT: apply the branch flushes; the FSM stays in PCWAIT.
//   - An r15 writer still in D at branch time is flushed, so no entry occurs.
//  Output combination: StallF/StallD/FlushD/FlushE are ORs of the LU, branch and PCWAIT terms.
//  StallCount:
//   - Increments by 1 each cycle StallD=1.
//   - Holds at 2^CNT_W-1 (no wrap).
//   - Cleared only by reset.
//  Mid-operation reset:
//   - Abandons PCWAIT and the shadow contents immediately.
//   - The first cycle after release behaves as from an empty pipe.
// TESTING
//  1. ADD r1,r2,r3 then SUB r4,r1,r5:
//     -> cycle SUB is in E: ForwardAE=10, no stall.
//     -> next instr using r1: ForwardAE=01.
//  2. LDR r1,[r2] then ADD r3,r1,r4:
//     -> one cycle StallF=StallD=FlushE=1, then ForwardBE=00/ForwardAE=01.
//     -> StallCount=1.
//  3. BranchTakenE=1 same cycle as an LU condition:
//     -> FlushD=FlushE=1, StallF=StallD=0, StallCount unchanged.
//  4. MOV r15,r0 in D:
//     -> PCWAIT for cycles until it reaches W (StallF=FlushD=1).
//     -> IDLE the cycle after; FSM state visible via outputs.
//  5. Forward to r15 source with M.wa=15:
//     -> ForwardAE=00.
//     -> M.wa=W.wa=7 both valid: ForwardAE=10 (M priority).
//  6. Hold LU for 2^CNT_W+3 cycles (CNT_W=4 override) -> StallCount saturates at 15.
//     -> Assert reset mid-PCWAIT: all outputs 0 immediately, StallCount=0.

Source files
------------

// File: rtl/hazard_scheduler.sv
// hazard_scheduler: hazard controller for the 5-stage ARM pipeline.
// It keeps a shadow copy of the instructions in E, M and W, built from the decode-stage
// fields. From that shadow it produces the load-use stall, the branch flushes, the
// PC-write (r15) wait sequence and the E-stage forwarding selects. It also counts stall
// cycles in a saturating counter.
//
// Ports:
//   clk, reset            clock; asynchronous active-low reset
//   ValidD                decode stage holds a real instruction
//   RA1D, RA2D, WA3D      decode read addresses and destination register
//   RegWriteD, MemToRegD  decode instruction writes a register / is a load
//   BranchTakenE          execute-stage branch resolved taken
//   StallF, StallD        hold PC / hold the fetch-decode register
//   FlushD, FlushE        bubble into the fetch-decode / decode-execute register
//   ForwardAE, ForwardBE  SrcA/SrcB select: 00 RD1E, 01 ResultW, 10 ALUResultM
//   StallCount            saturating count of cycles with StallD=1
module hazard_scheduler #(
    parameter int unsigned CNT_W  = 16,
    parameter logic [3:0]  PC_REG = 4'd15
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ValidD,
    input  logic [3:0]       RA1D,
    input  logic [3:0]       RA2D,
    input  logic [3:0]       WA3D,
    input  logic             RegWriteD,
    input  logic             MemToRegD,
    input  logic             BranchTakenE,
    output logic             StallF,
    output logic             StallD,
    output logic             FlushD,
    output logic             FlushE,
    output logic [1:0]       ForwardAE,
    output logic [1:0]       ForwardBE,
    output logic [CNT_W-1:0] StallCount
);

    typedef enum logic {StIdle, StPcWait} state_e;

    state_e state_q, state_d;

    // Shadow pipeline. Load status matters only while the instruction is in E.
    logic       e_v_q, e_rw_q, e_m2r_q;
    logic [3:0] e_wa_q, e_ra1_q, e_ra2_q;
    logic       m_v_q, m_rw_q;
    logic [3:0] m_wa_q;
    logic       w_v_q, w_rw_q;
    logic [3:0] w_wa_q;

    logic [CNT_W-1:0] count_q;

    logic       load_use, branch, pc_wait, w_writes_pc;
    logic       stall_f, stall_d, flush_d, flush_e;
    logic [1:0] fwd_a, fwd_b;

    always_comb begin
        load_use = ValidD & e_v_q & e_rw_q & e_m2r_q & ((e_wa_q == RA1D) | (e_wa_q == RA2D));
        branch   = BranchTakenE;
        pc_wait  = (state_q == StPcWait);

        // A taken branch removes the dependent instruction, so it suppresses the stall.
        stall_d  = load_use & ~branch;
        stall_f  = stall_d | pc_wait;
        flush_d  = branch | pc_wait;
        flush_e  = branch | load_use;

        w_writes_pc = w_v_q & w_rw_q & (w_wa_q == PC_REG);
    end

    // The PC is never forwarded: r15 reads come from the PC+8 path in decode.
    always_comb begin
        fwd_a = 2'b00;
        if (e_ra1_q != PC_REG) begin
            if (m_v_q && m_rw_q && (m_wa_q == e_ra1_q)) begin
                fwd_a = 2'b10;
            end else if (w_v_q && w_rw_q && (w_wa_q == e_ra1_q)) begin
                fwd_a = 2'b01;
            end
        end
        fwd_b = 2'b00;
        if (e_ra2_q != PC_REG) begin
            if (m_v_q && m_rw_q && (m_wa_q == e_ra2_q)) begin
                fwd_b = 2'b10;
            end else if (w_v_q && w_rw_q && (w_wa_q == e_ra2_q)) begin
                fwd_b = 2'b01;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (ValidD && RegWriteD && (WA3D == PC_REG) && !stall_d && !branch) begin
                    state_d = StPcWait;
                end
            end
            StPcWait: begin
                if (w_writes_pc) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            e_v_q   <= 1'b0;
            e_rw_q  <= 1'b0;
            e_m2r_q <= 1'b0;
            e_wa_q  <= 4'd0;
            e_ra1_q <= 4'd0;
            e_ra2_q <= 4'd0;
            m_v_q   <= 1'b0;
            m_rw_q  <= 1'b0;
            m_wa_q  <= 4'd0;
            w_v_q   <= 1'b0;
            w_rw_q  <= 1'b0;
            w_wa_q  <= 4'd0;
        end else begin
            w_v_q  <= m_v_q;
            w_rw_q <= m_rw_q;
            w_wa_q <= m_wa_q;
            m_v_q  <= e_v_q;
            m_rw_q <= e_rw_q;
            m_wa_q <= e_wa_q;
            if (flush_e) begin
                e_v_q   <= 1'b0;
                e_rw_q  <= 1'b0;
                e_m2r_q <= 1'b0;
                e_wa_q  <= 4'd0;
                e_ra1_q <= 4'd0;
                e_ra2_q <= 4'd0;
            end else begin
                e_v_q   <= ValidD;
                e_rw_q  <= RegWriteD;
                e_m2r_q <= MemToRegD;
                e_wa_q  <= WA3D;
                e_ra1_q <= RA1D;
                e_ra2_q <= RA2D;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_q <= '0;
        end else if (stall_d && (count_q != {CNT_W{1'b1}})) begin
            count_q <= count_q + CNT_W'(1);
        end
    end

    // Outputs are forced low while reset is held, including the terms driven by inputs.
    always_comb begin
        StallF     = reset & stall_f;
        StallD     = reset & stall_d;
        FlushD     = reset & flush_d;
        FlushE     = reset & flush_e;
        ForwardAE  = reset ? fwd_a : 2'b00;
        ForwardBE  = reset ? fwd_b : 2'b00;
        StallCount = count_q;
    end

endmodule

// File: tb/tb_hazard_scheduler.sv
module tb_hazard_scheduler;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          ValidD, RegWriteD, MemToRegD, BranchTakenE;
    logic [3:0]    RA1D, RA2D, WA3D;
    logic          StallF, StallD, FlushD, FlushE;
    logic [1:0]    ForwardAE, ForwardBE;
    logic [CW-1:0] StallCount;

    always #5 clk = ~clk;

    hazard_scheduler #(.CNT_W(CW), .PC_REG(4'd15)) dut (
        .clk(clk), .reset(reset), .ValidD(ValidD), .RA1D(RA1D), .RA2D(RA2D), .WA3D(WA3D),
        .RegWriteD(RegWriteD), .MemToRegD(MemToRegD), .BranchTakenE(BranchTakenE),
        .StallF(StallF), .StallD(StallD), .FlushD(FlushD), .FlushE(FlushE),
        .ForwardAE(ForwardAE), .ForwardBE(ForwardBE), .StallCount(StallCount)
    );

    // Reference model: a list of in-flight instructions plus a "waiting for PC" flag.
    typedef struct packed {
        logic       v;
        logic [3:0] wa;
        logic [3:0] ra1;
        logic [3:0] ra2;
        logic       rw;
        logic       m2r;
    } instr_t;

    instr_t slot_e, slot_m, slot_w;
    bit     waiting_pc;
    int     stalls;
    int     checks = 0;
    int     failures = 0;
    logic   last_sf, last_sd, last_fd, last_fe;
    logic [1:0] last_fa, last_fb;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        slot_e = '0;
        slot_m = '0;
        slot_w = '0;
        waiting_pc = 0;
        stalls = 0;
    endtask

    function automatic logic [1:0] source_of(input logic [3:0] r);
        if (r == 4'd15) return 2'b00;
        if (slot_m.v && slot_m.rw && slot_m.wa == r) return 2'b10;
        if (slot_w.v && slot_w.rw && slot_w.wa == r) return 2'b01;
        return 2'b00;
    endfunction

    // One clock cycle: apply decode fields, check outputs mid-cycle, then advance the model.
    task automatic step(input logic vd, input logic [3:0] a1, input logic [3:0] a2,
                        input logic [3:0] wa, input logic rw, input logic m2r, input logic br);
        bit hazard, hold, enter, leave;
        instr_t incoming;
        ValidD = vd; RA1D = a1; RA2D = a2; WA3D = wa;
        RegWriteD = rw; MemToRegD = m2r; BranchTakenE = br;
        #1;
        hazard = vd && slot_e.v && slot_e.rw && slot_e.m2r && (slot_e.wa == a1 || slot_e.wa == a2);
        hold   = hazard && !br;
        chk("StallD", 32'(StallD), 32'(hold));
        chk("StallF", 32'(StallF), 32'(hold || waiting_pc));
        chk("FlushD", 32'(FlushD), 32'(br || waiting_pc));
        chk("FlushE", 32'(FlushE), 32'(br || hazard));
        chk("ForwardAE", 32'(ForwardAE), 32'(source_of(slot_e.ra1)));
        chk("ForwardBE", 32'(ForwardBE), 32'(source_of(slot_e.ra2)));
        chk("StallCount", 32'(StallCount), 32'(stalls));
        last_sf = StallF; last_sd = StallD; last_fd = FlushD; last_fe = FlushE;
        last_fa = ForwardAE; last_fb = ForwardBE;
        @(posedge clk);
        enter = !waiting_pc && vd && rw && wa == 4'd15 && !hold && !br;
        leave = waiting_pc && slot_w.v && slot_w.rw && slot_w.wa == 4'd15;
        if (enter) waiting_pc = 1;
        else if (leave) waiting_pc = 0;
        if (hold && stalls < (1 << CW) - 1) stalls++;
        incoming = '{v: vd, wa: wa, ra1: a1, ra2: a2, rw: rw, m2r: m2r};
        slot_w = slot_m;
        slot_m = slot_e;
        slot_e = (br || hazard) ? instr_t'('0) : incoming;
        #1;
    endtask

    task automatic bubble();
        step(1'b0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        reset = 1'b0;
        ValidD = 1'b1; RA1D = 4'd1; RA2D = 4'd1; WA3D = 4'd15;
        RegWriteD = 1'b1; MemToRegD = 1'b1; BranchTakenE = 1'b1;
        model_clear();
        #12;
        // Reset held with active-looking inputs: everything must read zero.
        chk("rst_StallF", 32'(StallF), 0);
        chk("rst_FlushD", 32'(FlushD), 0);
        chk("rst_FlushE", 32'(FlushE), 0);
        chk("rst_StallCount", 32'(StallCount), 0);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;

        // ADD r1,r2,r3 ; SUB r4,r1,r5 ; ORR r6,r1,r1
        step(1, 4'd2, 4'd3, 4'd1, 1, 0, 0);
        step(1, 4'd1, 4'd5, 4'd4, 1, 0, 0);
        step(1, 4'd1, 4'd1, 4'd6, 1, 0, 0);
        chk("t1_fwdM", 32'(last_fa), 32'(2'b10));
        chk("t1_nostall", 32'(last_sd), 0);
        bubble();
        chk("t1_fwdW", 32'(last_fa), 32'(2'b01));
        bubble(); bubble(); bubble();

        // LDR r1,[r2] ; ADD r3,r1,r4 (stalled once)
        step(1, 4'd2, 4'd0, 4'd1, 1, 1, 0);
        step(1, 4'd1, 4'd4, 4'd3, 1, 0, 0);
        chk("t2_stall", 32'({last_sf, last_sd, last_fe}), 32'(3'b111));
        step(1, 4'd1, 4'd4, 4'd3, 1, 0, 0);
        bubble();
        chk("t2_fwdA", 32'(last_fa), 32'(2'b01));
        chk("t2_fwdB", 32'(last_fb), 32'(2'b00));
        chk("t2_count", 32'(StallCount), 1);
        bubble(); bubble();

        // Branch taken while a load-use condition is present.
        step(1, 4'd2, 4'd0, 4'd1, 1, 1, 0);
        step(1, 4'd1, 4'd4, 4'd3, 1, 0, 1);
        chk("t3_flush", 32'({last_fd, last_fe, last_sf, last_sd}), 32'(4'b1100));
        chk("t3_count", 32'(StallCount), 1);
        bubble(); bubble(); bubble();

        // MOV r15,r0: wait until it reaches W, idle the cycle after.
        step(1, 4'd0, 4'd0, 4'd15, 1, 0, 0);
        chk("t4_entry_idle", 32'(last_sf), 0);
        bubble();
        chk("t4_wait1", 32'({last_sf, last_fd}), 32'(2'b11));
        bubble(); bubble();
        chk("t4_wait3", 32'({last_sf, last_fd}), 32'(2'b11));
        bubble();
        chk("t4_idle", 32'({last_sf, last_fd}), 0);

        // r15 source is never forwarded; M wins over W.
        step(1, 4'd0, 4'd0, 4'd15, 1, 0, 0);
        step(1, 4'd15, 4'd0, 4'd2, 0, 0, 0);
        bubble();
        chk("t5_pc_nofwd", 32'(last_fa), 0);
        bubble(); bubble(); bubble();
        step(1, 4'd0, 4'd0, 4'd7, 1, 0, 0);
        step(1, 4'd0, 4'd0, 4'd7, 1, 0, 0);
        step(1, 4'd7, 4'd0, 4'd8, 0, 0, 0);
        bubble();
        chk("t5_mprio", 32'(last_fa), 32'(2'b10));
        bubble(); bubble();

        // Saturation: repeated load/use pairs, 2^CW+3 stalls in total.
        for (int i = 0; i < (1 << CW) + 3; i++) begin
            step(1, 4'd2, 4'd0, 4'd1, 1, 1, 0);
            step(1, 4'd1, 4'd3, 4'd3, 1, 0, 0);
        end
        chk("t6_sat", 32'(StallCount), 15);

        // Randomized traffic against the model.
        for (int i = 0; i < 400; i++) begin
            logic [3:0] r1, r2, rd;
            r1 = ($urandom_range(0, 9) == 0) ? 4'd15 : 4'($urandom_range(0, 3));
            r2 = 4'($urandom_range(0, 3));
            rd = ($urandom_range(0, 11) == 0) ? 4'd15 : 4'($urandom_range(0, 3));
            step(1'($urandom_range(0, 7) != 0), r1, r2, rd, 1'($urandom_range(0, 3) != 0),
                 1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 9) == 0));
        end

        // Mid-PCWAIT reset.
        bubble(); bubble(); bubble(); bubble();
        step(1, 4'd0, 4'd0, 4'd15, 1, 0, 0);
        bubble();
        chk("t6_in_wait", 32'(last_sf), 1);
        ValidD = 1; RA1D = 4'd1; RA2D = 4'd1; BranchTakenE = 1;
        #2;
        reset = 1'b0;
        #1;
        chk("t6_rst_outs", 32'({StallF, StallD, FlushD, FlushE, ForwardAE, ForwardBE}), 0);
        chk("t6_rst_count", 32'(StallCount), 0);
        model_clear();
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        bubble();
        chk("t6_after_rst", 32'({last_sf, last_fd}), 0);
        step(1, 4'd2, 4'd3, 4'd5, 1, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
